pkt_assembler: RTL

- Receive-side counterpart of the packet shift-out register.
- Collects a byte stream from the SPI slave front end, MSB byte first, into one PACKET_SIZE-bit packet.
- Presents the finished packet to the downstream command decoder with a valid/ready handshake.
- Enforces an inter-byte timeout, flags bytes dropped while a packet is pending, and optionally verifies a trailing XOR checksum byte.

---
 rtl/pkt_pkg.sv | 19 +
 rtl/pkt_timeout_ctr.sv | 37 +++
 rtl/pkt_assembler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
// Shared packet definitions for the SPI packet transmit/receive blocks.
package pkt_pkg;

  localparam int PKT_SIZE_DEF = 24;
  localparam int BYTE_W       = 8;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } pkt_state_e;

  function automatic logic [BYTE_W-1:0] chk_fold(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Saturating idle-cycle counter with synchronous clear; expire_o flags the last allowed idle cycle.
module pkt_timeout_ctr
  import pkt_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up and hold at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= {W{1'b0}};
    else      cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/pkt_assembler.sv
// Assembles a byte stream (first byte in the MSBs) into one packet with a valid/ready handoff.
// Build option: define PKT_CHECKSUM_EN to require a trailing XOR checksum byte per packet.
module pkt_assembler
  import pkt_pkg::*;
#(
  parameter int PACKET_SIZE    = PKT_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   byte_valid,
  input  logic                   pkt_ready,
  output logic [PACKET_SIZE-1:0] pkt_out,
  output logic                   pkt_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic                   chk_err
);

  localparam int NBYTES = PACKET_SIZE / BYTE_W;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PKT_CHECKSUM_EN
  localparam int FRAME_BYTES = NBYTES + 1;
`else
  localparam int FRAME_BYTES = NBYTES;
`endif
  localparam int CNT_W = $clog2(FRAME_BYTES + 1);

  pkt_state_e             state_q, state_d;
  logic [PACKET_SIZE-1:0] sreg_q, sreg_d, pkt_out_q, pkt_out_d, shift_s, done_val_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pkt_valid_q, busy_q;
  logic                   overrun_q, overrun_d, timeout_q, timeout_d;
  logic                   expire_s, last_byte_s, frame_ok_s, start_s;

  assign shift_s     = PACKET_SIZE'({sreg_q, byte_in});
  assign last_byte_s = (cnt_q == CNT_W'(FRAME_BYTES - 1));
  // a byte starts a new packet from IDLE, or from HOLD when it rides along with the handoff
  assign start_s     = byte_valid && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && pkt_ready));

  pkt_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES), .W(TO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q != ST_COLLECT) || byte_valid),
    .en_i     (state_q == ST_COLLECT),
    .expire_o (expire_s)
  );

`ifdef PKT_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic              chk_err_q, mismatch_s;

  assign frame_ok_s = (byte_in == xor_q);
  assign done_val_s = sreg_q;
  assign mismatch_s = byte_valid && (state_q == ST_COLLECT) && last_byte_s && !frame_ok_s;

  // running XOR of the data bytes of the current packet
  always_comb begin
    xor_d = xor_q;
    if (start_s) begin
      xor_d = byte_in;
    end else if (byte_valid && (state_q == ST_COLLECT) && !last_byte_s) begin
      xor_d = chk_fold(xor_q, byte_in);
    end else begin
      xor_d = xor_q;
    end
  end

  // checksum accumulator and mismatch pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_q     <= {BYTE_W{1'b0}};
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= mismatch_s;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign frame_ok_s = 1'b1;
  assign done_val_s = shift_s;
  assign chk_err    = 1'b0;
`endif

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sreg_q      <= {PACKET_SIZE{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      pkt_out_q   <= {PACKET_SIZE{1'b0}};
      pkt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      pkt_out_q   <= pkt_out_d;
      pkt_valid_q <= (state_d == ST_HOLD);
      busy_q      <= (state_d == ST_COLLECT);
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start_s)                       state_d = (FRAME_BYTES == 1) ? ST_HOLD : ST_COLLECT;
        else if (state_q == ST_HOLD && pkt_ready) state_d = ST_IDLE;
        else                               state_d = state_q;
      end
      ST_COLLECT: begin
        if (byte_valid && last_byte_s)     state_d = frame_ok_s ? ST_HOLD : ST_IDLE;
        else if (byte_valid)               state_d = ST_COLLECT;
        else if (expire_s)                 state_d = ST_IDLE;
        else                               state_d = ST_COLLECT;
      end
      default:                             state_d = ST_IDLE;
    endcase
  end

  // datapath and error-pulse next values
  always_comb begin
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    pkt_out_d = pkt_out_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (start_s && (FRAME_BYTES == 1)) begin
          pkt_out_d = shift_s;
          sreg_d    = {PACKET_SIZE{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
        end else if (start_s) begin
          sreg_d = shift_s;
          cnt_d  = CNT_W'(1);
        end else if (byte_valid && (state_q == ST_HOLD)) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (byte_valid && last_byte_s) begin
          pkt_out_d = frame_ok_s ? done_val_s : pkt_out_q;
          sreg_d    = {PACKET_SIZE{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
        end else if (byte_valid) begin
          sreg_d = shift_s;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (expire_s) begin
          timeout_d = 1'b1;
          sreg_d    = {PACKET_SIZE{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
        end else begin
          timeout_d = 1'b0;
        end
      end
      default: begin
        sreg_d = {PACKET_SIZE{1'b0}};
        cnt_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  assign pkt_out     = pkt_out_q;
  assign pkt_valid   = pkt_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
